nand_flash_target: RTL and testbench
====================================

NAND_FLASH_TARGET -- requirements
Module: nand_flash_target

Interface
REQ-001 SHALL have parameter DataWidth, default 16, meaning DIO/word width.
REQ-002 SHALL have parameter AddressWidth, default 16, meaning width of the address word driven on DIO during ALE.
REQ-003 SHALL have parameter PageAddrWidth, default 4, meaning number of pages = 2**PageAddrWidth.
REQ-004 SHALL have parameter PageWords, default 8, meaning words per page.
REQ-005 SHALL have parameters EraseCycles, default 16, and ProgCycles, default 8, meaning busy durations in clk cycles.
REQ-006 SHALL have ports: clk input 1 clock; Reset input 1 synchronous active-high reset; cEn input 1 chip enable; CLE input 1 command latch; ALE input 1 address latch; wEn input 1 write-data strobe; rEn input 1 read-data strobe; DIO inout tri DataWidth shared bus; status output 1 one-cycle completion pulse; busy output 1 operation in progress.

Function
REQ-007 SHALL sample all inputs on posedge clk and ignore every input while cEn=0 in IDLE.
REQ-008 SHALL implement states IDLE, ADDR_WAIT, ERASE_BUSY, PROG_LOAD, PROG_BUSY, READ_OUT, DONE.
REQ-009 IDLE: cEn=1 and CLE=1 SHALL latch DIO[2:0] as command; 0=erase, 1=program, 2=read go to ADDR_WAIT; any other code stays in IDLE with no status.
REQ-010 CLE and ALE both high SHALL be treated as CLE only.
REQ-011 ADDR_WAIT: cEn=1 and ALE=1 SHALL latch DIO[PageAddrWidth-1:0] as page address (upper bits ignored), clear word index, then go to ERASE_BUSY, PROG_LOAD or READ_OUT per command.
REQ-012 ERASE_BUSY: the block SHALL count EraseCycles cycles, set every word of the page to all-ones on the final cycle, then go to DONE.
REQ-013 PROG_LOAD: each cycle with wEn=1 SHALL store DIO into page word[index] and increment index; wEn=0 stalls; after word PageWords-1 the next state SHALL be PROG_BUSY.
REQ-014 PROG_BUSY: the block SHALL count ProgCycles cycles, then go to DONE.
REQ-015 READ_OUT: each cycle with rEn=1 SHALL drive DIO with page word[index] combinationally from the registered index and then increment it; rEn=0 SHALL stall with DIO high-Z; after word PageWords-1 the next state SHALL be DONE.
REQ-016 DIO SHALL be high-Z in all states except READ_OUT with rEn=1.
REQ-017 DONE SHALL assert status=1 for exactly one cycle, then return to IDLE.
REQ-018 busy SHALL be 1 in every state except IDLE and DONE.
REQ-019 CLE, ALE, wEn and rEn SHALL be ignored in ERASE_BUSY and PROG_BUSY, and CLE/ALE ignored in PROG_LOAD/READ_OUT.
REQ-020 cEn falling to 0 in ADDR_WAIT, PROG_LOAD or READ_OUT SHALL abort to IDLE with no status and no array change; cEn is ignored in ERASE_BUSY and PROG_BUSY.
REQ-021 The word index SHALL be $clog2(PageWords) bits and SHALL NOT wrap within a transfer.

Reset
REQ-022 Reset=1 SHALL force IDLE, status=0, busy=0, DIO high-Z, index=0 and counters=0 on the next posedge, including mid-operation.
REQ-023 Reset SHALL NOT alter array contents; the array SHALL start all-ones at time zero.
REQ-024 A program aborted by Reset SHALL keep any words already stored.

Configuration
REQ-025 Macro NAND_PROGRAM_AND_EN defined SHALL make program store old & new; undefined SHALL make program overwrite with new.

Structure
REQ-026 Package nand_pkg SHALL hold the command encodings (CMD_ERASE=0, CMD_PROGRAM=1, CMD_READ=2) and the state enum type.
REQ-027 The storage array SHALL be a sub-module nand_page_array with one synchronous write port and one asynchronous read port.

Verification
REQ-028 Erase page 3 -> busy for 16 cycles, page 3 reads 8x16'hFFFF, status pulses once.
REQ-029 Program page 5 with 16'h0001..16'h0008 after erase -> read returns 0001..0008 in order, and status pulses once after PROG_BUSY and once after READ_OUT.
REQ-030 With NAND_PROGRAM_AND_EN, program 16'h00FF then 16'h0F0F to word 0 without erase -> read 16'h000F; without the macro -> 16'h0F0F.
REQ-031 Command code 3 or 7 on CLE -> no state change, busy=0, no status.
REQ-032 Reset asserted at load word 4 of a program -> busy=0 next cycle, DIO high-Z; words 0-3 are retained and words 4-7 are unchanged.
REQ-033 rEn deasserted for 3 cycles mid-read -> DIO high-Z during the stall, and the next word is returned with no skip or repeat.

Source files
------------

// File: rtl/nand_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : nand_pkg                                               |
// | Description : Shared definitions for the NAND flash target model.    |
// |               Holds the command codes latched on DIO[2:0] during     |
// |               CLE and the controller state encoding.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package nand_pkg;

  localparam logic [2:0] CMD_ERASE   = 3'd0;
  localparam logic [2:0] CMD_PROGRAM = 3'd1;
  localparam logic [2:0] CMD_READ    = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ADDR_WAIT  = 3'd1,
    ST_ERASE_BUSY = 3'd2,
    ST_PROG_LOAD  = 3'd3,
    ST_PROG_BUSY  = 3'd4,
    ST_READ_OUT   = 3'd5,
    ST_DONE       = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/nand_page_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : nand_page_array                                        |
// | Description : Page-organised word storage. One synchronous write     |
// |               port (single word, or a whole page set to all-ones     |
// |               when erase_i is high) and one asynchronous read port.  |
// |               Contents power up all-ones (erased).                   |
// | Revision    : 1.0 - initial release                                  |
// | Ports       : clk      - clock                                       |
// |               we_i     - write one word at wpage_i/widx_i            |
// |               erase_i  - set every word of wpage_i to all-ones       |
// |               wpage_i, widx_i, wdata_i - write address/data          |
// |               rpage_i, ridx_i          - read address                |
// |               rdata_o  - asynchronous read data                      |
// +----------------------------------------------------------------------+
module nand_page_array import nand_pkg::*; #(
  parameter int DataWidth     = 16,
  parameter int PageAddrWidth = 4,
  parameter int PageWords     = 8,
  parameter int IdxWidth      = 3
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic                     erase_i,
  input  logic [PageAddrWidth-1:0] wpage_i,
  input  logic [IdxWidth-1:0]      widx_i,
  input  logic [DataWidth-1:0]     wdata_i,
  input  logic [PageAddrWidth-1:0] rpage_i,
  input  logic [IdxWidth-1:0]      ridx_i,
  output logic [DataWidth-1:0]     rdata_o
);

  localparam int Depth = (2 ** PageAddrWidth) * PageWords;
  localparam int AddrW = $clog2(Depth);

  // Erased state at power-up; reset deliberately never touches the array.
  logic [DataWidth-1:0] mem_q [Depth] = '{default: '1};

  logic [AddrW-1:0] wbase;
  logic [AddrW-1:0] waddr;
  logic [AddrW-1:0] raddr;

  assign wbase = AddrW'(wpage_i) * AddrW'(PageWords);
  assign waddr = wbase + AddrW'(widx_i);
  assign raddr = AddrW'(rpage_i) * AddrW'(PageWords) + AddrW'(ridx_i);

  always_ff @(posedge clk) begin
    if (erase_i) begin
      for (int w = 0; w < PageWords; w++) begin
        mem_q[wbase + AddrW'(w)] <= '1;
      end
    end else if (we_i) begin
      mem_q[waddr] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/nand_flash_target.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : nand_flash_target                                      |
// | Description : Simplified NAND flash target. Command on CLE, page     |
// |               address on ALE, then erase / program (wEn strobes) /   |
// |               read (rEn strobes) one page over the shared DIO bus.   |
// |               Optional macro NAND_PROGRAM_AND_EN: program stores     |
// |               old & new instead of overwriting.                      |
// | Revision    : 1.0 - initial release                                  |
// | Ports       : clk, Reset (sync, active-high), cEn, CLE, ALE, wEn,    |
// |               rEn - control inputs; DIO - bidirectional data bus;    |
// |               status - one-cycle completion pulse; busy - operation  |
// |               in progress.                                           |
// +----------------------------------------------------------------------+
module nand_flash_target import nand_pkg::*; #(
  parameter int DataWidth     = 16,
  parameter int AddressWidth  = 16,
  parameter int PageAddrWidth = 4,
  parameter int PageWords     = 8,
  parameter int EraseCycles   = 16,
  parameter int ProgCycles    = 8
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 cEn,
  input  logic                 CLE,
  input  logic                 ALE,
  input  logic                 wEn,
  input  logic                 rEn,
  inout  tri   [DataWidth-1:0] DIO,
  output logic                 status,
  output logic                 busy
);

  localparam int IdxW   = (PageWords > 1) ? $clog2(PageWords) : 1;
  localparam int MaxCyc = (EraseCycles > ProgCycles) ? EraseCycles : ProgCycles;
  localparam int CntW   = $clog2(MaxCyc + 1);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(PageWords - 1);
  localparam logic [CntW-1:0] EraseLast = CntW'(EraseCycles - 1);
  localparam logic [CntW-1:0] ProgLast  = CntW'(ProgCycles - 1);

  state_e                   state_q, state_d;
  logic [2:0]               cmd_q, cmd_d;
  logic [PageAddrWidth-1:0] page_q, page_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     arr_we;
  logic                     arr_erase;
  logic [DataWidth-1:0]     arr_rdata;
  logic [DataWidth-1:0]     arr_wdata;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_ERASE;
      page_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    page_d    = page_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    arr_we    = 1'b0;
    arr_erase = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // CLE wins over ALE, so ALE is not looked at here.
        if (cEn && CLE) begin
          cmd_d = DIO[2:0];
          if (DIO[2:0] == CMD_ERASE || DIO[2:0] == CMD_PROGRAM ||
              DIO[2:0] == CMD_READ) begin
            state_d = ST_ADDR_WAIT;
          end
        end
      end
      ST_ADDR_WAIT: begin
        if (!cEn) begin
          state_d = ST_IDLE;
        end else if (ALE && !CLE) begin
          page_d = DIO[PageAddrWidth-1:0];
          idx_d  = '0;
          cnt_d  = '0;
          case (cmd_q)
            CMD_ERASE:   state_d = ST_ERASE_BUSY;
            CMD_PROGRAM: state_d = ST_PROG_LOAD;
            default:     state_d = ST_READ_OUT;
          endcase
        end
      end
      ST_ERASE_BUSY: begin
        if (cnt_q == EraseLast) begin
          // Array writes are suppressed under Reset so it never alters contents.
          arr_erase = !Reset;
          cnt_d     = '0;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_PROG_LOAD: begin
        if (!cEn) begin
          state_d = ST_IDLE;
        end else if (wEn) begin
          arr_we = !Reset;
          if (idx_q == LastIdx) begin
            cnt_d   = '0;
            state_d = ST_PROG_BUSY;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      ST_PROG_BUSY: begin
        if (cnt_q == ProgLast) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_READ_OUT: begin
        if (!cEn) begin
          state_d = ST_IDLE;
        end else if (rEn) begin
          if (idx_q == LastIdx) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef NAND_PROGRAM_AND_EN
  // Programming can only clear bits, like real NAND cells.
  assign arr_wdata = arr_rdata & DIO;
`else
  assign arr_wdata = DIO;
`endif

  nand_page_array #(
    .DataWidth     (DataWidth),
    .PageAddrWidth (PageAddrWidth),
    .PageWords     (PageWords),
    .IdxWidth      (IdxW)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .erase_i (arr_erase),
    .wpage_i (page_q),
    .widx_i  (idx_q),
    .wdata_i (arr_wdata),
    .rpage_i (page_q),
    .ridx_i  (idx_q),
    .rdata_o (arr_rdata)
  );

  assign DIO    = (state_q == ST_READ_OUT && rEn) ? arr_rdata : {DataWidth{1'bz}};
  assign status = (state_q == ST_DONE);
  assign busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_nand_flash_target.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_nand_flash_target                                   |
// | Description : Randomised self-checking bench for nand_flash_target   |
// |               with a page-array reference model. Honours the         |
// |               NAND_PROGRAM_AND_EN macro.                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_nand_flash_target;

  localparam int DW        = 16;
  localparam int PAW       = 4;
  localparam int NPAGES    = 16;
  localparam int PW        = 8;
  localparam int ERASE_CYC = 16;
  localparam int PROG_CYC  = 8;
  // Undriven DIO floats to all-ones through the pull-up.
  localparam logic [DW-1:0] HIZ = '1;
`ifdef NAND_PROGRAM_AND_EN
  localparam bit AND_MODE = 1'b1;
`else
  localparam bit AND_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic Reset, cEn, CLE, ALE, wEn, rEn;
  logic [DW-1:0] tb_dat;
  logic tb_en;
  tri [DW-1:0] DIO;
  logic status, busy;

  pullup (DIO);
  assign DIO = tb_en ? tb_dat : {DW{1'bz}};

  nand_flash_target #(
    .DataWidth(DW), .AddressWidth(16), .PageAddrWidth(PAW), .PageWords(PW),
    .EraseCycles(ERASE_CYC), .ProgCycles(PROG_CYC)
  ) dut (
    .clk(clk), .Reset(Reset), .cEn(cEn), .CLE(CLE), .ALE(ALE),
    .wEn(wEn), .rEn(rEn), .DIO(DIO), .status(status), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] model [NPAGES][PW];
  logic [DW-1:0] wbuf [PW];

  function automatic logic [DW-1:0] prog_result(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w);
    return AND_MODE ? (old_w & new_w) : new_w;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cEn = 1'b0; CLE = 1'b0; ALE = 1'b0; wEn = 1'b0; rEn = 1'b0; tb_en = 1'b0;
  endtask

  task automatic junk_inputs();
    cEn = 1'($urandom); CLE = 1'($urandom); ALE = 1'($urandom);
    wEn = 1'($urandom); rEn = 1'($urandom); tb_en = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < PW; i++) begin
      wbuf[i] = DW'($urandom);
      if (wbuf[i] == HIZ) wbuf[i] = 16'h1234;
    end
  endtask

  task automatic send_cmd(input logic [2:0] code);
    cEn = 1'b1; CLE = 1'b1; ALE = 1'($urandom); wEn = 1'b0; rEn = 1'b0;
    tb_en = 1'b1; tb_dat = DW'($urandom); tb_dat[2:0] = code;
    tick();
    CLE = 1'b0; ALE = 1'b0; tb_en = 1'b0;
  endtask

  task automatic send_addr(input int page);
    ALE = 1'b1; CLE = 1'b0;
    tb_en = 1'b1; tb_dat = DW'($urandom); tb_dat[PAW-1:0] = PAW'(page);
    tick();
    ALE = 1'b0; tb_en = 1'b0;
  endtask

  // Counts busy cycles after the transfer/address phase and checks the DONE pulse.
  task automatic wait_busy_done(input string name, input int expect_cyc);
    int cyc;
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      n_tests++;
      if (status !== 1'b0) begin
        n_fail++; $display("FAIL %s_status_while_busy: got %b, expected 0", name, status);
      end
      junk_inputs();
      tick();
    end
    idle_inputs();
    n_tests++;
    if (cyc != expect_cyc) begin
      n_fail++; $display("FAIL %s_busy_len: got %0d cycles, expected %0d", name, cyc, expect_cyc);
    end
    n_tests++;
    if (status !== 1'b1) begin
      n_fail++; $display("FAIL %s_done_status: got %b, expected 1", name, status);
    end
    tick();
    n_tests++;
    if (status !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_after_done: got status=%b busy=%b, expected 0/0", name, status, busy);
    end
  endtask

  task automatic op_erase(input int page);
    send_cmd(3'd0);
    send_addr(page);
    wait_busy_done("erase", ERASE_CYC);
    for (int w = 0; w < PW; w++) model[page][w] = '1;
  endtask

  // Programs wbuf into page; reset_at >= 0 asserts Reset on that load word.
  task automatic op_program(input int page, input int reset_at);
    int n;
    send_cmd(3'd1);
    send_addr(page);
    for (int i = 0; i < PW; i++) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        wEn = 1'b0; tb_en = 1'b0; CLE = 1'($urandom); ALE = 1'($urandom);
        tick();
        n_tests++;
        if (busy !== 1'b1) begin
          n_fail++; $display("FAIL load_stall_busy: got %b, expected 1", busy);
        end
      end
      CLE = 1'b0; ALE = 1'b0;
      wEn = 1'b1; tb_en = 1'b1; tb_dat = wbuf[i];
      if (i == reset_at) begin
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        idle_inputs();
        #1;
        n_tests++;
        if (busy !== 1'b0 || status !== 1'b0 || DIO !== HIZ) begin
          n_fail++;
          $display("FAIL reset_mid_load: got busy=%b status=%b DIO=%h, expected 0/0/%h", busy, status, DIO, HIZ);
        end
        return;
      end
      tick();
      model[page][i] = prog_result(model[page][i], wbuf[i]);
    end
    wEn = 1'b0; tb_en = 1'b0;
    wait_busy_done("program", PROG_CYC);
  endtask

  task automatic op_read(input int page, input int stall_at, input int stall_len);
    int n;
    send_cmd(3'd2);
    send_addr(page);
    for (int i = 0; i < PW; i++) begin
      n = (i == stall_at) ? stall_len : $urandom_range(0, 1);
      repeat (n) begin
        rEn = 1'b0; CLE = 1'($urandom); ALE = 1'($urandom);
        #1;
        n_tests++;
        if (DIO !== HIZ) begin
          n_fail++; $display("FAIL read_stall_hiz: got DIO=%h, expected %h", DIO, HIZ);
        end
        tick();
      end
      CLE = 1'b0; ALE = 1'b0; rEn = 1'b1;
      #1;
      n_tests++;
      if (DIO !== model[page][i]) begin
        n_fail++; $display("FAIL read_word p%0d w%0d: got %h, expected %h", page, i, DIO, model[page][i]);
      end
      tick();
    end
    rEn = 1'b0;
    #1;
    n_tests++;
    if (status !== 1'b1 || busy !== 1'b0 || DIO !== HIZ) begin
      n_fail++; $display("FAIL read_done: got status=%b busy=%b DIO=%h, expected 1/0/%h", status, busy, DIO, HIZ);
    end
    idle_inputs();
    tick();
    n_tests++;
    if (status !== 1'b0) begin
      n_fail++; $display("FAIL read_status_once: got %b, expected 0", status);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; idle_inputs();
    repeat (3) tick();
    Reset = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || status !== 1'b0 || DIO !== HIZ) begin
      n_fail++; $display("FAIL reset_state: got busy=%b status=%b DIO=%h", busy, status, DIO);
    end
    // Power-up contents are all-ones.
    op_read(0, -1, 0);
    // Reset in the middle of a read.
    send_cmd(3'd2);
    send_addr(1);
    rEn = 1'b1; Reset = 1'b1;
    tick();
    Reset = 1'b0; idle_inputs();
    #1;
    n_tests++;
    if (busy !== 1'b0 || status !== 1'b0 || DIO !== HIZ) begin
      n_fail++; $display("FAIL reset_mid_read: got busy=%b status=%b DIO=%h", busy, status, DIO);
    end
  endtask

  task automatic test_erase();
    fill_random();
    op_program(3, -1);
    op_erase(3);
    op_read(3, -1, 0);
  endtask

  task automatic test_program_read();
    op_erase(5);
    for (int i = 0; i < PW; i++) wbuf[i] = DW'(i + 1);
    op_program(5, -1);
    op_read(5, -1, 0);
  endtask

  task automatic test_program_mode();
    op_erase(7);
    fill_random(); wbuf[0] = 16'h00FF;
    op_program(7, -1);
    fill_random(); wbuf[0] = 16'h0F0F;
    op_program(7, -1);
    op_read(7, -1, 0);
  endtask

  task automatic test_bad_cmd();
    logic [2:0] code;
    for (int k = 0; k < 6; k++) begin
      code = (k < 2) ? ((k == 0) ? 3'd3 : 3'd7) : 3'($urandom_range(3, 7));
      send_cmd(code);
      #1;
      n_tests++;
      if (busy !== 1'b0 || status !== 1'b0) begin
        n_fail++; $display("FAIL bad_cmd %0d: got busy=%b status=%b, expected 0/0", code, busy, status);
      end
      send_addr($urandom_range(0, NPAGES - 1));
      n_tests++;
      if (busy !== 1'b0) begin
        n_fail++; $display("FAIL bad_cmd_then_ale %0d: got busy=%b, expected 0", code, busy);
      end
      idle_inputs();
    end
    // Chip not enabled: a valid command must be ignored.
    cEn = 1'b0; CLE = 1'b1; tb_en = 1'b1; tb_dat = '0;
    tick();
    idle_inputs();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL cen_low_ignored: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_abort();
    fill_random();
    op_program(2, -1);
    // Abort in ADDR_WAIT: the erase must not happen.
    send_cmd(3'd0);
    cEn = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b0 || status !== 1'b0) begin
      n_fail++; $display("FAIL abort_addr_wait: got busy=%b status=%b, expected 0/0", busy, status);
    end
    cEn = 1'b1;
    send_addr(2);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_then_ale: got busy=%b, expected 0", busy);
    end
    idle_inputs();
    // Abort on the first load word: nothing written.
    send_cmd(3'd1);
    send_addr(2);
    cEn = 1'b0; wEn = 1'b1; tb_en = 1'b1; tb_dat = DW'($urandom);
    tick();
    idle_inputs();
    n_tests++;
    if (busy !== 1'b0 || status !== 1'b0) begin
      n_fail++; $display("FAIL abort_prog_load: got busy=%b status=%b, expected 0/0", busy, status);
    end
    // Abort part way through a read.
    send_cmd(3'd2);
    send_addr(2);
    rEn = 1'b1;
    tick(); tick();
    cEn = 1'b0; rEn = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b0 || status !== 1'b0) begin
      n_fail++; $display("FAIL abort_read: got busy=%b status=%b, expected 0/0", busy, status);
    end
    idle_inputs();
    op_read(2, -1, 0);
  endtask

  task automatic test_reset_mid_program();
    op_erase(9);
    fill_random();
    op_program(9, 4);
    op_read(9, -1, 0);
  endtask

  task automatic test_read_stall();
    op_read(5, 3, 3);
  endtask

  task automatic test_random();
    int pg;
    int kind;
    for (int k = 0; k < 8; k++) begin
      pg = $urandom_range(0, NPAGES - 1);
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        op_erase(pg);
      end else if (kind == 1) begin
        fill_random();
        op_program(pg, -1);
      end
      op_read(pg, $urandom_range(0, PW - 1), $urandom_range(0, 3));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int p = 0; p < NPAGES; p++)
      for (int w = 0; w < PW; w++) model[p][w] = '1;
    Reset = 1'b1; tb_dat = '0;
    idle_inputs();
    tick();
    test_reset();
    test_erase();
    test_program_read();
    test_program_mode();
    test_bad_cmd();
    test_abort();
    test_reset_mid_program();
    test_read_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
